keyboard_event_ctrl: RTL and testbench
======================================

// Module: keyboard_event_ctrl
// PURPOSE
//  Sequences the PS/2 receiver byte stream into discrete key events for game logic.
//  Parses make/break(F0) frames, tracks held keys, generates typematic repeat, and
//  buffers press/release/repeat events in a small FIFO drained via valid/ready.
//  Sits between the PS/2 rx (rx_done_tick/dout) and the game/menu controllers.
// PARAMETERS
//  FIFO_DEPTH     4           event FIFO entries, power of 2, >=2
//  REPEAT_DELAY   32_500_000  clk cycles held before first repeat (0.5 s @ 65 MHz)
//  REPEAT_PERIOD  6_500_000   clk cycles between subsequent repeats (100 ms)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous active-high reset
//  rx_done_tick  in   1  one-cycle strobe, dout valid
//  dout          in   8  received scancode byte
//  ev_ready      in   1  consumer accepts head event
//  ev_valid      out  1  FIFO not empty
//  ev_key        out  4  head event key code (vga_pkg key_*)
//  ev_press      out  1  1 = press/repeat, 0 = release
//  ev_repeat     out  1  1 = auto-repeat event
//  held          out 16  bitmap of currently held keys, indexed by key code
//  ovf           out  1  sticky: an event was dropped (FIFO full)
// BEHAVIOUR
//  - One clock; rst asynchronous active-high. Reset: ev_valid=0, ev_key=0, ev_press=0,
//    ev_repeat=0, held=0, ovf=0, FIFO empty, FSM IDLE, repeat disarmed.
//  - Scancode map: 1C A, 1B S, 23 D, 1D W, 16 1, 1E 2, 26 3, 25 4, 76 ESC; others unmapped.
//  - FSM (advances only on rx_done_tick): IDLE: F0->BREAK; mapped->make; else stay.
//    BREAK: any byte->IDLE; mapped->break action. Unmapped bytes never generate events.
//  - Make: key not held -> set held bit, push {key,press=1,repeat=0}, make it repeat key,
//    load repeat counter with REPEAT_DELAY. Key already held (keyboard typematic) -> ignore.
//  - Break: held bit set -> clear it, push {key,press=0,repeat=0}; if repeat key, disarm.
//    Break of non-held key -> no event.
//  - Repeat: armed counter decrements each cycle; at 0 push {key,1,1} only if FIFO empty
//    (else tick skipped), reload REPEAT_PERIOD either way.
//  - Latency: byte sampled at edge N -> event in FIFO, ev_valid=1 from cycle N+1.
//  - FIFO: pop on ev_valid&ev_ready; head outputs registered from FIFO read pointer.
//    Full & push & no pop -> event dropped, ovf<=1 (cleared only by rst).
//    Full & push & pop same cycle -> both performed, no drop.
//    Repeat push and byte push same cycle -> byte event wins, repeat tick skipped.
//  - Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
// CONFIGURATION
//  KEYBOARD_EXT_EN defined: E0 prefix parsed; states EXT (after E0) and EXT_BREAK
//    (E0 F0). Arrows alias: E0 75->W, E0 72->S, E0 6B->A, E0 74->D; other E0 codes
//    ignored, FSM returns IDLE after the final byte.
//  Undefined: E0 treated as unmapped byte in IDLE; following byte decoded normally
//    (75/72/6B/74 unmapped -> no event). Same ports either way.
// STRUCTURE
//  - vga_pkg: existing key_* 4-bit codes; add KEY_NUM=16 and SC_* scancode constants
//    (SC_BREAK=8'hF0, SC_EXT=8'hE0, per-key codes).
//  - Sub-module keyboard_event_fifo: parameterised sync FIFO (push/pop/full/empty,
//    6-bit payload {key,press,repeat}); parser, held bitmap, repeat timer in top.
// TESTING
//  1 Reset mid-stream: F0 then rst pulse, then 1C -> press A event, held[key_A]=1.
//  2 1C, F0 1C with ev_ready=1 -> press A then release A; held returns to 0.
//  3 1C, 1C, 1C (keyboard typematic) -> exactly one press event; REPEAT_DELAY=20,
//    PERIOD=5 small params -> repeat events at +20,+25,+30 cycles, ev_repeat=1.
//  4 ev_ready=0, five makes (1C 1B 23 1D 16) with DEPTH=4 -> 4 events kept, fifth
//    dropped, ovf=1; push+pop same cycle when full -> no drop.
//  5 Unmapped 5A, F0 5A, F0 of non-held key -> no events, FSM back to IDLE.
//  6 KEYBOARD_EXT_EN: E0 75, E0 F0 75 -> press W, release W; without macro -> no events.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared key codes, PS/2 scancode constants and keyboard event types
// Scancode decoders are used by keyboard_event_ctrl (KEYBOARD_EXT_EN selects the E0 decoder).
package vga_pkg;

  localparam logic [3:0] key_A   = 4'd0;
  localparam logic [3:0] key_S   = 4'd1;
  localparam logic [3:0] key_D   = 4'd2;
  localparam logic [3:0] key_W   = 4'd3;
  localparam logic [3:0] key_1   = 4'd4;
  localparam logic [3:0] key_2   = 4'd5;
  localparam logic [3:0] key_3   = 4'd6;
  localparam logic [3:0] key_4   = 4'd7;
  localparam logic [3:0] key_ESC = 4'd8;
  localparam int         KEY_NUM = 16;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_EXT, ST_EXT_BREAK} kbd_state_t;

  typedef struct packed {
    logic [3:0] key;
    logic       press;
    logic       rpt;
  } key_event_t;

  localparam int EV_W = $bits(key_event_t);

  typedef struct packed {
    logic       hit;
    logic [3:0] key;
  } key_map_t;

  function automatic key_map_t sc_decode(input logic [7:0] sc);
    key_map_t m;
    m = '{hit: 1'b1, key: key_A};
    case (sc)
      SC_A:    m.key = key_A;
      SC_S:    m.key = key_S;
      SC_D:    m.key = key_D;
      SC_W:    m.key = key_W;
      SC_1:    m.key = key_1;
      SC_2:    m.key = key_2;
      SC_3:    m.key = key_3;
      SC_4:    m.key = key_4;
      SC_ESC:  m.key = key_ESC;
      default: m.hit = 1'b0;
    endcase
    return m;
  endfunction

  // Arrow keys after an E0 prefix alias onto the WASD codes.
  function automatic key_map_t sc_decode_ext(input logic [7:0] sc);
    key_map_t m;
    m = '{hit: 1'b1, key: key_A};
    case (sc)
      SC_UP:    m.key = key_W;
      SC_DOWN:  m.key = key_S;
      SC_LEFT:  m.key = key_A;
      SC_RIGHT: m.key = key_D;
      default:  m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/keyboard_event_fifo.sv
// rtl/keyboard_event_fifo.sv - small synchronous FIFO holding key events
// A push while full is accepted only when a pop happens in the same cycle.
module keyboard_event_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = EV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/keyboard_event_ctrl.sv
// rtl/keyboard_event_ctrl.sv - PS/2 scancode parser, held-key bitmap, typematic repeat, event FIFO
// Define KEYBOARD_EXT_EN to parse E0-prefixed arrow keys as aliases of W/S/A/D.
module keyboard_event_ctrl
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 32_500_000,
  parameter int REPEAT_PERIOD = 6_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done_tick,
  input  logic [7:0]  dout,
  input  logic        ev_ready,
  output logic        ev_valid,
  output logic [3:0]  ev_key,
  output logic        ev_press,
  output logic        ev_repeat,
  output logic [15:0] held,
  output logic        ovf
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  kbd_state_t    state_q, state_d;
  logic [15:0]   held_q, held_d;
  logic          armed_q, armed_d;
  logic [3:0]    rep_key_q, rep_key_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          ovf_q, ovf_d;

  key_map_t      m;
  logic          act_make, act_break, byte_push, rep_fire;
  logic [3:0]    act_key;
  key_event_t    byte_ev, fifo_din, head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign m        = sc_decode(dout);
`ifdef KEYBOARD_EXT_EN
  key_map_t      mx;
  assign mx       = sc_decode_ext(dout);
`endif
  assign rep_fire = armed_q && (rep_cnt_q == '0);
  assign ev_valid = !fifo_empty;
  assign fifo_pop = ev_valid && ev_ready;

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    armed_d   = armed_q;
    rep_key_d = rep_key_q;
    rep_cnt_d = rep_cnt_q;
    ovf_d     = ovf_q;
    act_make  = 1'b0;
    act_break = 1'b0;
    act_key   = '0;
    byte_push = 1'b0;
    byte_ev   = '0;

    if (armed_q) rep_cnt_d = rep_fire ? RW'(REPEAT_PERIOD - 1) : rep_cnt_q - 1'b1;

    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (dout == SC_BREAK) state_d = ST_BREAK;
`ifdef KEYBOARD_EXT_EN
          else if (dout == SC_EXT) state_d = ST_EXT;
`endif
          else begin
            act_make = m.hit;
            act_key  = m.key;
          end
        end
        ST_BREAK: begin
          state_d   = ST_IDLE;
          act_break = m.hit;
          act_key   = m.key;
        end
`ifdef KEYBOARD_EXT_EN
        ST_EXT: begin
          if (dout == SC_BREAK) state_d = ST_EXT_BREAK;
          else begin
            state_d  = ST_IDLE;
            act_make = mx.hit;
            act_key  = mx.key;
          end
        end
        ST_EXT_BREAK: begin
          state_d   = ST_IDLE;
          act_break = mx.hit;
          act_key   = mx.key;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    // Keyboard typematic re-sends a make for a held key; only the first one counts.
    if (act_make && !held_q[act_key]) begin
      held_d[act_key] = 1'b1;
      byte_push       = 1'b1;
      byte_ev         = '{key: act_key, press: 1'b1, rpt: 1'b0};
      armed_d         = 1'b1;
      rep_key_d       = act_key;
      rep_cnt_d       = RW'(REPEAT_DELAY - 1);
    end
    if (act_break && held_q[act_key]) begin
      held_d[act_key] = 1'b0;
      byte_push       = 1'b1;
      byte_ev         = '{key: act_key, press: 1'b0, rpt: 1'b0};
      if (rep_key_q == act_key) armed_d = 1'b0;
    end

    if (byte_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // Byte events take the FIFO slot; a repeat tick only lands in an empty FIFO.
  assign fifo_push = byte_push || (rep_fire && fifo_empty);
  assign fifo_din  = byte_push ? byte_ev : '{key: rep_key_q, press: 1'b1, rpt: 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      held_q    <= '0;
      armed_q   <= 1'b0;
      rep_key_q <= '0;
      rep_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      armed_q   <= armed_d;
      rep_key_q <= rep_key_d;
      rep_cnt_q <= rep_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  keyboard_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (EV_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .din_i  (fifo_din),
    .pop_i  (fifo_pop),
    .dout_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign ev_key    = ev_valid ? head.key   : '0;
  assign ev_press  = ev_valid && head.press;
  assign ev_repeat = ev_valid && head.rpt;
  assign held      = held_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_keyboard_event_ctrl.sv
// tb/tb_keyboard_event_ctrl.sv - scoreboard bench: event-level reference model vs keyboard_event_ctrl
module tb_keyboard_event_ctrl;
  import vga_pkg::*;

  localparam int DEPTH = 4;
  localparam int DLY   = 20;
  localparam int PER   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  dout = 8'h00;
  logic        ev_ready = 1'b0;
  logic        ev_valid, ev_press, ev_repeat, ovf;
  logic [3:0]  ev_key;
  logic [15:0] held;

  keyboard_event_ctrl #(
    .FIFO_DEPTH   (DEPTH),
    .REPEAT_DELAY (DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_done_tick(rx_done_tick),
    .dout        (dout),
    .ev_ready    (ev_ready),
    .ev_valid    (ev_valid),
    .ev_key      (ev_key),
    .ev_press    (ev_press),
    .ev_repeat   (ev_repeat),
    .held        (held),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: events encoded as key*4 + press*2 + repeat.
  int          mq[$];
  int          exp_q[$];
  bit [15:0]   m_held;
  bit          m_ovf, m_brk, m_ext, m_armed;
  int          m_rkey, m_rem;
  int          m_ev;
  bit          m_bp;

  function automatic int map_sc(input logic [7:0] b);
    case (b)
      8'h1C: return int'(key_A);
      8'h1B: return int'(key_S);
      8'h23: return int'(key_D);
      8'h1D: return int'(key_W);
      8'h16: return int'(key_1);
      8'h1E: return int'(key_2);
      8'h26: return int'(key_3);
      8'h25: return int'(key_4);
      8'h76: return int'(key_ESC);
      default: return -1;
    endcase
  endfunction

  function automatic int map_ext(input logic [7:0] b);
    case (b)
      8'h75: return int'(key_W);
      8'h72: return int'(key_S);
      8'h6B: return int'(key_A);
      8'h74: return int'(key_D);
      default: return -1;
    endcase
  endfunction

  task automatic m_make(input int k);
    if (k >= 0 && !m_held[k]) begin
      m_held[k] = 1'b1;
      m_ev = k * 4 + 2;
      m_bp = 1'b1;
      m_armed = 1'b1;
      m_rkey = k;
      m_rem = DLY;
    end
  endtask

  task automatic m_break(input int k);
    if (k >= 0 && m_held[k]) begin
      m_held[k] = 1'b0;
      m_ev = k * 4;
      m_bp = 1'b1;
      if (m_rkey == k) m_armed = 1'b0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_held = '0; m_ovf = 0; m_brk = 0; m_ext = 0; m_armed = 0; m_rkey = 0; m_rem = 0;
    end else begin
      bit was_empty, full, pop, fire;
      was_empty = (mq.size() == 0);
      full = (mq.size() == DEPTH);
      pop = !was_empty && ev_ready;
      fire = 0;
      if (m_armed) begin
        m_rem--;
        if (m_rem == 0) begin fire = 1; m_rem = PER; end
      end
      m_bp = 0;
      if (rx_done_tick) begin
`ifdef KEYBOARD_EXT_EN
        if (m_ext) begin
          if (!m_brk && dout == 8'hF0) m_brk = 1;
          else begin
            if (m_brk) m_break(map_ext(dout)); else m_make(map_ext(dout));
            m_ext = 0; m_brk = 0;
          end
        end else
`endif
        if (m_brk) begin m_brk = 0; m_break(map_sc(dout)); end
        else if (dout == 8'hF0) m_brk = 1;
`ifdef KEYBOARD_EXT_EN
        else if (dout == 8'hE0) m_ext = 1;
`endif
        else m_make(map_sc(dout));
      end
      if (pop) void'(mq.pop_front());
      if (m_bp) begin
        if (full && !pop) m_ovf = 1;
        else begin mq.push_back(m_ev); exp_q.push_back(m_ev); end
      end else if (fire && was_empty) begin
        mq.push_back(m_rkey * 4 + 3);
        exp_q.push_back(m_rkey * 4 + 3);
      end
    end
  end

  // Monitor / scoreboard: the only process that counts comparisons.
  int n_checks = 0, n_pass = 0;
  int rd_idx = 0;
  int dir_seq = 0, seen_seq = 0, dir_kind = 0;
  int evt_cnt = 0, press_cnt = 0, press_cyc = 0;
  int rep_gap[$];

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", int'(ev_valid), 0);
      chk("rst_head", {ev_key, ev_press, ev_repeat}, 0);
      chk("rst_held", int'(held), 0);
      chk("rst_ovf", int'(ovf), 0);
      rd_idx = exp_q.size();
    end else begin
      chk("ev_valid", int'(ev_valid), int'(mq.size() != 0));
      chk("held", int'(held), int'(m_held));
      chk("ovf", int'(ovf), int'(m_ovf));
      if (ev_valid && ev_ready) begin
        evt_cnt++;
        if (rd_idx < exp_q.size()) begin
          chk("event", {ev_key, ev_press, ev_repeat}, exp_q[rd_idx]);
          rd_idx++;
        end else begin
          chk("event_unexpected", {ev_key, ev_press, ev_repeat}, -1);
        end
        if (ev_press && !ev_repeat) begin press_cnt++; press_cyc = cyc; end
        if (ev_repeat) rep_gap.push_back(cyc - press_cyc);
      end
    end
    if (dir_seq != seen_seq) begin
      seen_seq = dir_seq;
      case (dir_kind)
        0: begin evt_cnt = 0; press_cnt = 0; rep_gap.delete(); end
        1: begin
          chk("t1_held_A", int'(held[key_A]), 1);
          chk("t1_events", evt_cnt, 1);
        end
        2: begin
          chk("t2_held", int'(held), 0);
          chk("t2_events", evt_cnt, 2);
        end
        3: begin
          chk("t3_press_count", press_cnt, 1);
          chk("t3_repeat_count", rep_gap.size(), 3);
          for (int i = 0; i < 3; i++)
            chk($sformatf("t3_repeat_gap%0d", i), (i < rep_gap.size()) ? rep_gap[i] : -1, DLY + i * PER);
        end
        4: begin
          chk("t4_ovf", int'(ovf), 1);
          chk("t4_held", int'(held), int'((16'd1 << key_A) | (16'd1 << key_S) | (16'd1 << key_D)
                                         | (16'd1 << key_W) | (16'd1 << key_1)));
        end
        5: chk("t4_events_after_full_pop", evt_cnt, 5);
        6: begin
          chk("t5_events", evt_cnt, 1);
          chk("t5_held", int'(held), int'(16'd1 << key_A));
        end
`ifdef KEYBOARD_EXT_EN
        7: chk("t6_events", evt_cnt, 2);
`else
        7: chk("t6_events", evt_cnt, 0);
`endif
        8: chk("drained", exp_q.size() - rd_idx, 0);
        default: ;
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1;
    dout = b;
    idle(1);
    rx_done_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic directed(input int kind);
    dir_kind = kind;
    dir_seq++;
    idle(1);
  endtask

  logic [7:0] pool [16] = '{8'h1C, 8'h1B, 8'h23, 8'h1D, 8'h16, 8'h1E, 8'h26, 8'h76,
                            8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'h75, 8'h72, 8'h5A, 8'h6B};

  initial begin
    idle(1);
    // 1: reset in the middle of a break sequence
    ev_ready = 1'b1;
    do_reset();
    directed(0);
    send(8'hF0);
    do_reset();
    send(8'h1C);
    idle(2);
    directed(1);

    // 2: press and release
    do_reset();
    directed(0);
    send(8'h1C); idle(2); send(8'hF0); send(8'h1C); idle(3);
    directed(2);

    // 3: keyboard typematic ignored, auto-repeat timing
    do_reset();
    directed(0);
    send(8'h1C); idle(2); send(8'h1C); send(8'h1C); idle(26);
    send(8'hF0); send(8'h1C); idle(6);
    directed(3);

    // 4: overflow, then push and pop together while full
    do_reset();
    directed(0);
    ev_ready = 1'b0;
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h1D); send(8'h16); idle(1);
    directed(4);
    send(8'hF0);
    ev_ready = 1'b1;
    send(8'h1C);
    idle(8);
    directed(5);

    // 5: unmapped bytes and break of a non-held key
    do_reset();
    directed(0);
    send(8'h5A); send(8'hF0); send(8'h5A); send(8'hF0); send(8'h1B); idle(2);
    send(8'h1C); idle(3);
    directed(6);

    // 6: extended arrow codes
    do_reset();
    directed(0);
    send(8'hE0); send(8'h75); idle(2); send(8'hE0); send(8'hF0); send(8'h75); idle(3);
    directed(7);

    // Random traffic with varying consumer back-pressure
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int thr;
      thr = (i / 250) % 3;
      ev_ready = ($urandom_range(0, 3) > thr) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        rx_done_tick = 1'b1;
        dout = pool[$urandom_range(0, 15)];
      end else begin
        rx_done_tick = 1'b0;
      end
      idle(1);
    end
    rx_done_tick = 1'b0;
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'hF0 == 8'h00 ? 8'h00 : 8'h00);
    idle(10);
    directed(8);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
